// File: rtl/wb_dp_ram_burst_pkg.sv
// wb_dp_ram_burst_pkg: Wishbone B4 cycle/burst-type codes and the burst address increment helper.
// Revision: 1.0

`default_nettype none

package wb_dp_ram_burst_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   // Widest word address the helper handles; callers truncate to their own width,
   // which also clamps a wrap window that is larger than the memory.
   localparam int ADR_MAX = 64;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } burst_state_t;

   function automatic logic [ADR_MAX-1:0] wb_burst_next(input logic [ADR_MAX-1:0] adr,
                                                        input logic [1:0]         bte);
      logic [ADR_MAX-1:0] nxt;
      nxt = adr;
      unique case (bte)
         BTE_LINEAR: nxt      = adr + ADR_MAX'(1);
         BTE_WRAP4:  nxt[1:0] = adr[1:0] + 2'd1;
         BTE_WRAP8:  nxt[2:0] = adr[2:0] + 3'd1;
         BTE_WRAP16: nxt[3:0] = adr[3:0] + 4'd1;
         default:    nxt      = adr;
      endcase
      return nxt;
   endfunction

endpackage

`default_nettype wire

// File: rtl/wb_dp_ram_burst_if.sv
// wb_dp_ram_burst_if: one Wishbone B4 slave port with registered-feedback burst tags.
// Revision: 1.0

`default_nettype none

interface wb_dp_ram_burst_if #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 16,
   parameter int SELECT_WIDTH = 4
);
   logic [ADDR_WIDTH-1:0]   adr_i;
   logic [DATA_WIDTH-1:0]   dat_i;
   logic [DATA_WIDTH-1:0]   dat_o;
   logic                    we_i;
   logic [SELECT_WIDTH-1:0] sel_i;
   logic                    stb_i;
   logic                    cyc_i;
   logic [2:0]              cti_i;
   logic [1:0]              bte_i;
   logic                    ack_o;

   modport master (
      output adr_i, dat_i, we_i, sel_i, stb_i, cyc_i, cti_i, bte_i,
      input  dat_o, ack_o
   );

   modport slave (
      input  adr_i, dat_i, we_i, sel_i, stb_i, cyc_i, cti_i, bte_i,
      output dat_o, ack_o
   );
endinterface

`default_nettype wire

// File: rtl/wb_dp_ram_burst_ctrl.sv
// wb_dp_ram_burst_ctrl: per-port ack/burst FSM; predicts the next word during incrementing bursts.
// Revision: 1.0

`default_nettype none

module wb_dp_ram_burst_ctrl
   import wb_dp_ram_burst_pkg::*;
#(
   parameter int VALID_ADDR_WIDTH = 14,
   parameter bit BURST_ENABLE     = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_req,
   input  logic                        i_we,
   input  logic [VALID_ADDR_WIDTH-1:0] i_adr,
   input  logic [2:0]                  i_cti,
   input  logic [1:0]                  i_bte,
   output logic                        o_ack,
   output logic                        o_rd_en,
   output logic [VALID_ADDR_WIDTH-1:0] o_rd_adr,
   output logic                        o_wr_en,
   output logic [VALID_ADDR_WIDTH-1:0] o_wr_adr
);

   burst_state_t                r_state;
   burst_state_t                w_state_nxt;
   logic                        r_ack;
   logic                        w_ack_nxt;
   logic [VALID_ADDR_WIDTH-1:0] r_burst_adr;
   logic [VALID_ADDR_WIDTH-1:0] w_burst_adr_nxt;
   logic                        w_incr;

   assign w_incr = BURST_ENABLE && (i_cti == CTI_INCR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_ack       <= 1'b0;
         r_burst_adr <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_ack       <= w_ack_nxt;
         r_burst_adr <= w_burst_adr_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_ack_nxt       = 1'b0;
      w_burst_adr_nxt = r_burst_adr;
      o_rd_en         = 1'b0;
      o_rd_adr        = i_adr;
      unique case (r_state)
         ST_IDLE: begin
            // A classic single leaves ack high for one cycle, so the held request is ignored once.
            if (i_req && !r_ack) begin
               w_ack_nxt = 1'b1;
               o_rd_en   = !i_we;
               if (w_incr) begin
                  w_state_nxt     = ST_BURST;
                  w_burst_adr_nxt = VALID_ADDR_WIDTH'(wb_burst_next(ADR_MAX'(i_adr), i_bte));
               end
            end
         end
         ST_BURST: begin
            // The next beat's read data comes from the predicted address, not the bus.
            if (i_req && w_incr) begin
               w_ack_nxt       = 1'b1;
               o_rd_en         = 1'b1;
               o_rd_adr        = r_burst_adr;
               w_burst_adr_nxt = VALID_ADDR_WIDTH'(wb_burst_next(ADR_MAX'(r_burst_adr), i_bte));
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign o_ack    = r_ack;
   assign o_wr_en  = i_req && i_we && r_ack;
   assign o_wr_adr = i_adr;

endmodule

`default_nettype wire

// File: rtl/wb_dp_ram_burst.sv
// wb_dp_ram_burst: dual-port Wishbone B4 byte-lane RAM with registered-feedback bursts on both ports.
// Revision: 1.0

`default_nettype none

module wb_dp_ram_burst
   import wb_dp_ram_burst_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 16,
   parameter int SELECT_WIDTH = 4,
   parameter bit BURST_ENABLE = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   wb_dp_ram_burst_if.slave  a,
   wb_dp_ram_burst_if.slave  b
);

   localparam int SEL_BITS         = $clog2(SELECT_WIDTH);
   localparam int VALID_ADDR_WIDTH = ADDR_WIDTH - SEL_BITS;
   localparam int WORD_SIZE        = DATA_WIDTH / SELECT_WIDTH;
   localparam int DEPTH            = 1 << VALID_ADDR_WIDTH;

   logic [DATA_WIDTH-1:0]       r_mem [DEPTH];

   logic [VALID_ADDR_WIDTH-1:0] w_a_word;
   logic                        w_a_req;
   logic                        w_a_ack;
   logic                        w_a_rd_en;
   logic [VALID_ADDR_WIDTH-1:0] w_a_rd_adr;
   logic                        w_a_wr_en;
   logic [VALID_ADDR_WIDTH-1:0] w_a_wr_adr;
   logic [DATA_WIDTH-1:0]       r_a_dat;

   logic [VALID_ADDR_WIDTH-1:0] w_b_word;
   logic                        w_b_req;
   logic                        w_b_ack;
   logic                        w_b_rd_en;
   logic [VALID_ADDR_WIDTH-1:0] w_b_rd_adr;
   logic                        w_b_wr_en;
   logic [VALID_ADDR_WIDTH-1:0] w_b_wr_adr;
   logic [DATA_WIDTH-1:0]       r_b_dat;

   assign w_a_word = VALID_ADDR_WIDTH'(a.adr_i >> SEL_BITS);
   assign w_b_word = VALID_ADDR_WIDTH'(b.adr_i >> SEL_BITS);
   assign w_a_req  = a.cyc_i && a.stb_i;
   assign w_b_req  = b.cyc_i && b.stb_i;

   wb_dp_ram_burst_ctrl #(
      .VALID_ADDR_WIDTH (VALID_ADDR_WIDTH),
      .BURST_ENABLE     (BURST_ENABLE)
   ) u_ctrl_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_req    (w_a_req),
      .i_we     (a.we_i),
      .i_adr    (w_a_word),
      .i_cti    (a.cti_i),
      .i_bte    (a.bte_i),
      .o_ack    (w_a_ack),
      .o_rd_en  (w_a_rd_en),
      .o_rd_adr (w_a_rd_adr),
      .o_wr_en  (w_a_wr_en),
      .o_wr_adr (w_a_wr_adr)
   );

   wb_dp_ram_burst_ctrl #(
      .VALID_ADDR_WIDTH (VALID_ADDR_WIDTH),
      .BURST_ENABLE     (BURST_ENABLE)
   ) u_ctrl_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_req    (w_b_req),
      .i_we     (b.we_i),
      .i_adr    (w_b_word),
      .i_cti    (b.cti_i),
      .i_bte    (b.bte_i),
      .o_ack    (w_b_ack),
      .o_rd_en  (w_b_rd_en),
      .o_rd_adr (w_b_rd_adr),
      .o_wr_en  (w_b_wr_en),
      .o_wr_adr (w_b_wr_adr)
   );

   // B is applied before A so that A's lanes take precedence on a same-word collision.
   always_ff @(posedge clk) begin
      if (w_b_wr_en) begin
         for (int i = 0; i < SELECT_WIDTH; i++) begin
            if (b.sel_i[i]) begin
               r_mem[w_b_wr_adr][i*WORD_SIZE +: WORD_SIZE] <= b.dat_i[i*WORD_SIZE +: WORD_SIZE];
            end
         end
      end
      if (w_a_wr_en) begin
         for (int i = 0; i < SELECT_WIDTH; i++) begin
            if (a.sel_i[i]) begin
               r_mem[w_a_wr_adr][i*WORD_SIZE +: WORD_SIZE] <= a.dat_i[i*WORD_SIZE +: WORD_SIZE];
            end
         end
      end
   end

   // Reads sample the array before this edge's writes land, giving read-first collisions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_dat <= '0;
      end else if (w_a_rd_en) begin
         r_a_dat <= r_mem[w_a_rd_adr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_b_dat <= '0;
      end else if (w_b_rd_en) begin
         r_b_dat <= r_mem[w_b_rd_adr];
      end
   end

   assign a.ack_o = w_a_ack;
   assign a.dat_o = r_a_dat;
   assign b.ack_o = w_b_ack;
   assign b.dat_o = r_b_dat;

endmodule

`default_nettype wire

// File: tb/tb_wb_dp_ram_burst.sv
// tb_wb_dp_ram_burst: directed and randomized Wishbone traffic on both ports against an array model.
// Revision: 1.0

`default_nettype none

module tb_wb_dp_ram_burst;
   import wb_dp_ram_burst_pkg::*;

   localparam int MDEPTH = 1 << 14;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   logic [31:0] mdl [MDEPTH];

   wb_dp_ram_burst_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .SELECT_WIDTH(4)) ifa ();
   wb_dp_ram_burst_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .SELECT_WIDTH(4)) ifb ();

   wb_dp_ram_burst #(
      .DATA_WIDTH   (32),
      .ADDR_WIDTH   (16),
      .SELECT_WIDTH (4),
      .BURST_ENABLE (1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (ifa.slave),
      .b     (ifb.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic set_bus(input int p, input logic cyc, input logic we, input logic [15:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel, input logic [2:0] cti,
                          input logic [1:0] bte);
      if (p == 0) begin
         ifa.cyc_i = cyc; ifa.stb_i = cyc; ifa.we_i = we; ifa.adr_i = adr;
         ifa.dat_i = dat; ifa.sel_i = sel; ifa.cti_i = cti; ifa.bte_i = bte;
      end else begin
         ifb.cyc_i = cyc; ifb.stb_i = cyc; ifb.we_i = we; ifb.adr_i = adr;
         ifb.dat_i = dat; ifb.sel_i = sel; ifb.cti_i = cti; ifb.bte_i = bte;
      end
   endtask

   task automatic idle(input int p);
      set_bus(p, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, CTI_CLASSIC, 2'b00);
   endtask

   function automatic logic get_ack(input int p);
      return (p == 0) ? ifa.ack_o : ifb.ack_o;
   endfunction

   function automatic logic [31:0] get_dat(input int p);
      return (p == 0) ? ifa.dat_o : ifb.dat_o;
   endfunction

   task automatic mdl_wr(input int w, input logic [31:0] d, input logic [3:0] s);
      for (int i = 0; i < 4; i++) begin
         if (s[i]) mdl[w][i*8 +: 8] = d[i*8 +: 8];
      end
   endtask

   // Word touched by beat k: linear walks the whole memory, wrap-N cycles inside an aligned N-word block.
   function automatic int beat_word(input int start, input int bte, input int k);
      int len;
      if (bte == 0) return (start + k) % MDEPTH;
      len = 2 ** (bte + 1);
      return (start / len) * len + (start + k) % len;
   endfunction

   task automatic classic(input int p, input logic we, input int w, input logic [31:0] d,
                          input logic [3:0] s, input string tag);
      set_bus(p, 1'b1, we, 16'(w * 4), d, s, CTI_CLASSIC, 2'b00);
      tick();
      chk($sformatf("%s ack", tag), 32'(get_ack(p)), 32'd1);
      if (we) mdl_wr(w, d, s);
      else    chk($sformatf("%s dat", tag), get_dat(p), mdl[w]);
      tick();
      chk($sformatf("%s ack_drop", tag), 32'(get_ack(p)), 32'd0);
      idle(p);
   endtask

   task automatic burst(input int p, input logic we, input int start, input int bte,
                        input int n, input string tag);
      logic [31:0] d;
      int          w;
      d = $urandom;
      w = beat_word(start, bte, 0);
      set_bus(p, 1'b1, we, 16'(w * 4), d, 4'hF, CTI_INCR, 2'(bte));
      tick();
      for (int k = 0; k < n; k++) begin
         chk($sformatf("%s ack beat%0d", tag, k), 32'(get_ack(p)), 32'd1);
         if (we) mdl_wr(w, d, 4'hF);
         else    chk($sformatf("%s dat beat%0d", tag, k), get_dat(p), mdl[w]);
         tick();
         if (k < n - 1) begin
            d = $urandom;
            w = beat_word(start, bte, k + 1);
            set_bus(p, 1'b1, we, 16'(w * 4), d, 4'hF, (k + 1 == n - 1) ? CTI_EOB : CTI_INCR, 2'(bte));
         end
      end
      chk($sformatf("%s ack_end", tag), 32'(get_ack(p)), 32'd0);
      idle(p);
   endtask

   initial begin
      logic [31:0] old_val;
      logic [31:0] d0;
      n_checks = 0;
      n_errors = 0;
      clk      = 1'b0;
      rst_n    = 1'b0;
      for (int i = 0; i < MDEPTH; i++) mdl[i] = 32'h0;
      idle(0);
      idle(1);
      tick();
      tick();
      chk("reset a_ack", 32'(ifa.ack_o), 32'd0);
      chk("reset a_dat", ifa.dat_o, 32'h0);
      chk("reset b_ack", 32'(ifb.ack_o), 32'd0);
      chk("reset b_dat", ifb.dat_o, 32'h0);
      rst_n = 1'b1;
      tick();

      // Classic write then read at byte address 0x10.
      classic(0, 1'b1, 4, 32'hDEADBEEF, 4'hF, "t1 wr");
      classic(0, 1'b0, 4, 32'h0, 4'h0, "t1 rd");
      chk("t1 value", ifa.dat_o, 32'hDEADBEEF);

      // Byte-lane write over a cleared word.
      classic(0, 1'b1, 0, 32'h0, 4'hF, "t2 clr");
      classic(0, 1'b1, 0, 32'h11223344, 4'b0101, "t2 wr");
      classic(0, 1'b0, 0, 32'h0, 4'h0, "t2 rd");
      chk("t2 value", ifa.dat_o, 32'h00220044);

      // Linear and wrap read bursts over words holding their own index.
      for (int i = 0; i < 8; i++) classic(0, 1'b1, i, 32'(i), 4'hF, "t3 pre");
      burst(1, 1'b0, 0, 0, 8, "t3 lin");
      burst(1, 1'b0, 6, 1, 4, "t4 wrap4");
      burst(0, 1'b0, 5, 2, 8, "t4 wrap8");

      // Same-edge writes to one word: A owns the overlapping lane.
      classic(0, 1'b1, 9, 32'h12345678, 4'hF, "t5 pre");
      set_bus(0, 1'b1, 1'b1, 16'(9 * 4), 32'hAAAAAAAA, 4'b1100, CTI_CLASSIC, 2'b00);
      set_bus(1, 1'b1, 1'b1, 16'(9 * 4), 32'hBBBBBBBB, 4'b0110, CTI_CLASSIC, 2'b00);
      tick();
      chk("t5 a_ack", 32'(ifa.ack_o), 32'd1);
      chk("t5 b_ack", 32'(ifb.ack_o), 32'd1);
      mdl_wr(9, 32'hBBBBBBBB, 4'b0110);
      mdl_wr(9, 32'hAAAAAAAA, 4'b1100);
      tick();
      idle(0);
      idle(1);
      tick();
      classic(1, 1'b0, 9, 32'h0, 4'h0, "t5 rd");
      chk("t5 merged", ifb.dat_o, 32'hAAAABB78);

      // A write and B read of the same word on the same edge: B sees the old contents.
      old_val = mdl[9];
      set_bus(0, 1'b1, 1'b1, 16'(9 * 4), 32'hCAFEF00D, 4'hF, CTI_CLASSIC, 2'b00);
      tick();
      set_bus(1, 1'b1, 1'b0, 16'(9 * 4), 32'h0, 4'h0, CTI_CLASSIC, 2'b00);
      tick();
      idle(0);
      mdl_wr(9, 32'hCAFEF00D, 4'hF);
      chk("t5 rdfirst ack", 32'(ifb.ack_o), 32'd1);
      chk("t5 rdfirst dat", ifb.dat_o, old_val);
      tick();
      idle(1);
      tick();
      classic(1, 1'b0, 9, 32'h0, 4'h0, "t5 rdnew");

      // Strobe dropped during the third beat aborts the burst.
      set_bus(1, 1'b1, 1'b0, 16'h0, 32'h0, 4'h0, CTI_INCR, 2'b00);
      tick();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("t6 abort ack beat%0d", k), 32'(ifb.ack_o), 32'd1);
         chk($sformatf("t6 abort dat beat%0d", k), ifb.dat_o, mdl[k]);
         if (k < 2) begin
            tick();
            set_bus(1, 1'b1, 1'b0, 16'((k + 1) * 4), 32'h0, 4'h0, CTI_INCR, 2'b00);
         end
      end
      ifb.stb_i = 1'b0;
      tick();
      chk("t6 abort ack_low", 32'(ifb.ack_o), 32'd0);
      idle(1);
      tick();
      classic(1, 1'b0, 3, 32'h0, 4'h0, "t6 after_abort");

      // Randomized traffic over a preloaded window.
      burst(0, 1'b1, 0, 0, 80, "rnd preload");
      for (int i = 0; i < 24; i++) begin
         int p;
         int op;
         int st;
         int bt;
         p  = int'($urandom_range(0, 1));
         op = int'($urandom_range(0, 3));
         st = int'($urandom_range(0, 63));
         bt = int'($urandom_range(0, 3));
         case (op)
            0: classic(p, 1'b0, st, 32'h0, 4'h0, $sformatf("rnd%0d crd", i));
            1: classic(p, 1'b1, st, $urandom, 4'($urandom), $sformatf("rnd%0d cwr", i));
            2: burst(p, 1'b0, st, bt, int'($urandom_range(2, 8)), $sformatf("rnd%0d brd", i));
            default: burst(p, 1'b1, st, bt, int'($urandom_range(2, 8)), $sformatf("rnd%0d bwr", i));
         endcase
         tick();
      end

      // Reset during the third beat of a write burst: ack clears at once, that beat is lost.
      d0 = $urandom;
      set_bus(0, 1'b1, 1'b1, 16'(20 * 4), d0, 4'hF, CTI_INCR, 2'b00);
      tick();
      chk("t6 rst beat0", 32'(ifa.ack_o), 32'd1);
      mdl_wr(20, d0, 4'hF);
      tick();
      d0 = $urandom;
      set_bus(0, 1'b1, 1'b1, 16'(21 * 4), d0, 4'hF, CTI_INCR, 2'b00);
      chk("t6 rst beat1", 32'(ifa.ack_o), 32'd1);
      mdl_wr(21, d0, 4'hF);
      tick();
      set_bus(0, 1'b1, 1'b1, 16'(22 * 4), $urandom, 4'hF, CTI_INCR, 2'b00);
      chk("t6 rst beat2", 32'(ifa.ack_o), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6 rst async ack", 32'(ifa.ack_o), 32'd0);
      chk("t6 rst async dat", ifa.dat_o, 32'h0);
      tick();
      idle(0);
      rst_n = 1'b1;
      tick();
      for (int w = 20; w < 23; w++) classic(0, 1'b0, w, 32'h0, 4'h0, $sformatf("t6 rst word%0d", w));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
